// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED bank sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        S_STATIC = 2'd0,
        S_BLINK  = 2'd1,
        S_CHASE  = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_CHASE  = 2'b10;

    // Reset brightness is "always on"; sliced down to PWM_BITS at use.
    localparam logic [31:0] BRIGHT_FULL = 32'hFFFF_FFFF;

    // Reserved mode 11 falls back to static.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_BLINK: return S_BLINK;
            MODE_CHASE: return S_CHASE;
            default:    return S_STATIC;
        endcase
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Two-level free-running prescaler: base tick every TICK_DIV cycles,
// step every BLINK_TICKS ticks. Synchronous clear restarts both counts.
module led_prescaler #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o,
    output logic step_o
);
    localparam int TW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int SW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic          tick_wrap, step_wrap;

    assign tick_wrap = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign step_wrap = (step_cnt_q == SW'(BLINK_TICKS - 1));

    // Pulses are suppressed on a clear so a restart never also counts as a step.
    assign tick_o = tick_wrap & ~clr_i;
    assign step_o = tick_o & step_wrap;

    // Next count: clear wins, otherwise the tick counter wraps into the step counter.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        step_cnt_d = step_cnt_q;
        if (clr_i) begin
            tick_cnt_d = '0;
            step_cnt_d = '0;
        end else if (tick_wrap) begin
            tick_cnt_d = '0;
            step_cnt_d = step_wrap ? '0 : step_cnt_q + SW'(1);
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED bank sequencer: host config port, fault override, static/blink/chase
// sequencing and PWM dimming. led is registered from current state only.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [7:0]          wr_pattern,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_bright,
    input  logic                fault,
    input  logic [7:0]          fault_code,
    output logic [7:0]          led,
    output logic [1:0]          cur_state
);
    state_t              state_q, state_d;
    logic [7:0]          pattern_q, pattern_d;
    logic [1:0]          mode_q, mode_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                phase_q, phase_d;
    logic [7:0]          led_q, led_d;
    logic                rst_n_q;
    logic                accept, pwm_on, step;

    assign wr_ready  = rst_n_q & (state_q != S_FAULT);
    assign accept    = wr_valid & wr_ready;
    assign pwm_on    = (bright_q == BRIGHT_FULL[PWM_BITS-1:0]) | (pwm_cnt_q < bright_q);
    assign led       = led_q;
    assign cur_state = state_q;

    led_prescaler #(
        .TICK_DIV    (TICK_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .tick_o (),
        .step_o (step)
    );

    // Next state: per-state step actions, fault preemption, then host write.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        bright_d  = bright_q;
        phase_d   = phase_q;

        case (state_q)
            S_BLINK: if (step) phase_d = ~phase_q;
            S_CHASE: if (step) pattern_d = {pattern_q[6:0], pattern_q[7]};
            S_FAULT: begin
                if (!fault) begin
                    state_d = mode_to_state(mode_q);
                    phase_d = 1'b1;
                end else if (step) begin
                    phase_d = ~phase_q;
                end
            end
            default: ;
        endcase

        if (state_q != S_FAULT && fault)
            state_d = S_FAULT;

        // A write can only land outside S_FAULT; a coincident fault still wins the
        // state, but the new config is saved and shown once the fault clears.
        if (accept) begin
            pattern_d = wr_pattern;
            mode_d    = (wr_mode == 2'b11) ? MODE_STATIC : wr_mode;
            bright_d  = wr_bright;
            phase_d   = 1'b1;
            if (!fault)
                state_d = mode_to_state(wr_mode);
        end
    end

    // Output decode from registered state; fault code ignores dimming.
    always_comb begin
        led_d = 8'h00;
        case (state_q)
            S_STATIC: led_d = pattern_q & {8{pwm_on}};
            S_BLINK:  led_d = pattern_q & {8{pwm_on & phase_q}};
            S_CHASE:  led_d = pattern_q & {8{pwm_on}};
            S_FAULT:  led_d = fault_code & {8{phase_q}};
            default:  led_d = 8'h00;
        endcase
    end

    // State, config, PWM counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_STATIC;
            pattern_q <= 8'h00;
            mode_q    <= MODE_STATIC;
            bright_q  <= BRIGHT_FULL[PWM_BITS-1:0];
            pwm_cnt_q <= '0;
            phase_q   <= 1'b1;
            led_q     <= 8'h00;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            phase_q   <= phase_d;
            led_q     <= led_d;
            rst_n_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_led_ctrl;
    localparam int TD  = 4;
    localparam int BT  = 2;
    localparam int PB  = 4;
    localparam int PER = TD * BT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_pattern = 8'h00;
    logic [1:0]    wr_mode = 2'b00;
    logic [PB-1:0] wr_bright = '0;
    logic          fault = 1'b0;
    logic [7:0]    fault_code = 8'h00;
    logic [7:0]    led;
    logic [1:0]    cur_state;

    int checks = 0;
    int failures = 0;

    led_ctrl #(.TICK_DIV(TD), .BLINK_TICKS(BT), .PWM_BITS(PB)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_pattern(wr_pattern), .wr_mode(wr_mode), .wr_bright(wr_bright),
        .fault(fault), .fault_code(fault_code), .led(led), .cur_state(cur_state)
    );

    always #5 clk = ~clk;

    // Behavioural model: config, fault flag, cycles since last restart, PWM phase.
    logic [7:0]    m_pat = 8'h00, m_led = 8'h00;
    logic [1:0]    m_mode = 2'd0;
    logic [PB-1:0] m_bright = '1, m_pwm = '0;
    logic          m_fault = 1'b0, m_phase = 1'b1, m_rdyq = 1'b0;
    int            m_since = 0;
    logic          m_on, m_step, m_acc;
    logic [1:0]    exp_state;
    logic          exp_rdy;

    assign exp_rdy   = m_rdyq && !m_fault;
    assign exp_state = m_fault ? 2'd3 : m_mode;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_led = 8'h00; m_pat = 8'h00; m_mode = 2'd0; m_bright = '1; m_fault = 1'b0;
            m_phase = 1'b1; m_since = 0; m_pwm = '0; m_rdyq = 1'b0;
        end else begin
            m_acc  = wr_valid && m_rdyq && !m_fault;
            m_on   = (m_bright == {PB{1'b1}}) || (m_pwm < m_bright);
            m_step = !m_acc && (m_since == PER - 1);
            if (m_fault)          m_led = m_phase ? fault_code : 8'h00;
            else if (m_mode == 1) m_led = (m_on && m_phase) ? m_pat : 8'h00;
            else                  m_led = m_on ? m_pat : 8'h00;
            if (m_acc) begin
                m_pat = wr_pattern; m_mode = (wr_mode == 2'd3) ? 2'd0 : wr_mode;
                m_bright = wr_bright; m_phase = 1'b1; m_since = 0; m_fault = fault;
            end else begin
                m_since = (m_since + 1) % PER;
                if (m_fault) begin
                    if (!fault) begin m_fault = 1'b0; m_phase = 1'b1; end
                    else if (m_step) m_phase = !m_phase;
                end else begin
                    if (m_step && m_mode == 2'd1) m_phase = !m_phase;
                    if (m_step && m_mode == 2'd2) m_pat = {m_pat[6:0], m_pat[7]};
                    if (fault) m_fault = 1'b1;
                end
            end
            m_pwm  = m_pwm + 1'b1;
            m_rdyq = 1'b1;
        end
    end

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Waits (bounded) for wr_ready, then presents one write for one edge.
    // Returns at the negedge following the accepting edge.
    task automatic do_write(input logic [7:0] p, input logic [1:0] m,
                            input logic [PB-1:0] b, input logic f);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready_timeout: wr_ready=%b required 1", wr_ready);
        end
        wr_valid = 1'b1; wr_pattern = p; wr_mode = m; wr_bright = b; fault = f;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 8'h00)     begin failures++; $display("FAIL reset_led: got %h required 00", led); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", wr_ready); end
        checks++; if (cur_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", cur_state); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b required 1", wr_ready); end
    endtask

    task automatic test_static();
        int on_cnt;
        do_write(8'hA5, 2'b00, 4'hF, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            checks++;
            if (led !== 8'hA5) begin failures++; $display("FAIL static_full k=%0d: got %h required a5", k, led); end
        end
        do_write(8'hA5, 2'b00, 4'h4, 1'b0);
        on_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (led === 8'hA5) on_cnt++;
            checks++;
            if (led !== m_led || (led !== 8'hA5 && led !== 8'h00)) begin
                failures++; $display("FAIL static_pwm k=%0d: got %h required %h", k, led, m_led);
            end
        end
        checks++;
        if (on_cnt != 8) begin failures++; $display("FAIL static_pwm_duty: on=%0d of 32 required 8", on_cnt); end
    endtask

    task automatic test_blink();
        logic [7:0] e;
        do_write(8'h3C, 2'b01, 4'hF, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            e = (((k - 1) / 8) % 2 == 0) ? 8'h3C : 8'h00;
            checks++;
            if (led !== e) begin failures++; $display("FAIL blink k=%0d: got %h required %h", k, led, e); end
        end
    endtask

    task automatic test_chase();
        logic [7:0] e;
        do_write(8'h81, 2'b10, 4'hF, 1'b0);
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            e = rotl(8'h81, ((k - 1) / 8) % 8);
            checks++;
            if (led !== e) begin failures++; $display("FAIL chase k=%0d: got %h required %h", k, led, e); end
        end
    endtask

    task automatic test_fault();
        int seen_on, seen_off;
        seen_on = 0; seen_off = 0;
        fault_code = 8'hFF;
        fault = 1'b1;
        @(negedge clk);
        checks++; if (cur_state !== 2'd3) begin failures++; $display("FAIL fault_state: got %0d required 3", cur_state); end
        checks++; if (wr_ready !== 1'b0)  begin failures++; $display("FAIL fault_ready: got %b required 0", wr_ready); end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (led === 8'hFF) seen_on++;
            if (led === 8'h00) seen_off++;
            checks++;
            if (led !== m_led) begin failures++; $display("FAIL fault_blink k=%0d: got %h required %h", k, led, m_led); end
        end
        checks++;
        if (seen_on == 0 || seen_off == 0 || seen_on + seen_off != 32) begin
            failures++; $display("FAIL fault_blink_mix: on=%0d off=%0d required both", seen_on, seen_off);
        end
        fault = 1'b0;
        @(negedge clk);
        checks++; if (cur_state !== 2'd2) begin failures++; $display("FAIL fault_exit_state: got %0d required 2", cur_state); end
        checks++; if (wr_ready !== 1'b1)  begin failures++; $display("FAIL fault_exit_ready: got %b required 1", wr_ready); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (led !== m_led) begin failures++; $display("FAIL chase_resume k=%0d: got %h required %h", k, led, m_led); end
        end
    endtask

    task automatic test_simultaneous();
        fault_code = 8'hC3;
        do_write(8'h0F, 2'b00, 4'hF, 1'b1);
        checks++; if (cur_state !== 2'd3) begin failures++; $display("FAIL simul_state: got %0d required 3", cur_state); end
        checks++; if (wr_ready !== 1'b0)  begin failures++; $display("FAIL simul_ready: got %b required 0", wr_ready); end
        @(negedge clk);
        checks++; if (led !== 8'hC3) begin failures++; $display("FAIL simul_fault_led: got %h required c3", led); end
        fault = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (led !== 8'h0F)      begin failures++; $display("FAIL simul_new_cfg: got %h required 0f", led); end
        checks++; if (cur_state !== 2'd0) begin failures++; $display("FAIL simul_exit_state: got %0d required 0", cur_state); end
        fault = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (led !== 8'h00)      begin failures++; $display("FAIL fault_reset_led: got %h required 00", led); end
        checks++; if (cur_state !== 2'd0) begin failures++; $display("FAIL fault_reset_state: got %0d required 0", cur_state); end
        checks++; if (wr_ready !== 1'b0)  begin failures++; $display("FAIL fault_reset_ready: got %b required 0", wr_ready); end
        rst_n = 1'b1; fault = 1'b0;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1)  begin failures++; $display("FAIL fault_reset_release: got %b required 1", wr_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (led !== m_led || wr_ready !== exp_rdy || cur_state !== exp_state) begin
                failures++;
                $display("FAIL random c=%0d: led=%h rdy=%b st=%0d required led=%h rdy=%b st=%0d",
                         c, led, wr_ready, cur_state, m_led, exp_rdy, exp_state);
            end
            wr_valid   = ($urandom_range(0, 15) == 0);
            wr_pattern = 8'($urandom);
            wr_mode    = 2'($urandom);
            wr_bright  = PB'($urandom);
            fault_code = 8'($urandom);
            if ($urandom_range(0, 39) == 0) fault = ~fault;
            rst_n = ($urandom_range(0, 299) != 0);
        end
        wr_valid = 1'b0; fault = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_chase();
        test_fault();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
